// File: rtl/uart_rx_engine.sv
// uart_rx_engine: receive-side UART deserializer feeding the RX FIFO.
// The line is synchronized, a start edge is detected, and each bit is
// sampled in its centre using a down-counting bit-period counter.
// Optional feature macro: UART_RX_PARITY_SUPPORT_EN. When it is defined, the
// PARITY state and parity check are built. When it is undefined, no parity bit
// is sampled and parity_err_o is tied low.
// Handshake: push_o is a one-cycle strobe with data_o valid in the same cycle;
// the FIFO has no ready path, so a full FIFO drops the byte and pulses overflow_o.
// state_o exposes the FSM state for debug and checkers.
module uart_rx_engine #(
    parameter int unsigned DIV_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  logic                 clk_en_i,
    input  logic                 parity_en_i,
    input  logic                 parity_type_i,
    input  logic                 stop_bits_i,
    input  logic [DIV_WIDTH-1:0] clk_div_i,
    input  logic                 rx_i,
    input  logic                 fifo_full_i,
    output logic                 push_o,
    output logic [7:0]           data_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 overflow_o,
    output logic                 busy_o,
    output logic [2:0]           state_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(2);

    state_t               state_q;
    state_t               state_d;
    logic                 sync1_q;
    logic                 rx_s;
    logic                 rx_prev_q;
    logic                 fall;
    logic                 tick;
    logic                 last_bit;
    logic [DIV_WIDTH-1:0] div_eff;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [2:0]           bit_cnt_q;
    logic [7:0]           shift_q;
    logic                 stop2_q;
    logic                 ferr_q;
`ifdef UART_RX_PARITY_SUPPORT_EN
    logic                 par_en_q;
    logic                 par_type_q;
    logic                 perr_q;
`else
    // Parity configuration has no effect in this build.
    logic                 unused_parity_cfg;
    assign unused_parity_cfg = parity_en_i ^ parity_type_i;
`endif

    // A falling edge needs a high sample first, so a held-low line never restarts.
    assign fall     = rx_prev_q & ~rx_s;
    assign tick     = (cnt_q == '0);
    assign last_bit = (bit_cnt_q == 3'd7);
    // Divisors below 2 are clamped so that half is never zero.
    assign div_eff  = (clk_div_i < DIV_MIN) ? DIV_MIN : clk_div_i;
    assign data_o   = shift_q;
    assign state_o  = state_q;

    // Two-flop line synchronizer plus the previous-sample flop for edge detection.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sync1_q   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= rx_i;
            rx_s      <= sync1_q;
            rx_prev_q <= rx_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clk_en_i low forces IDLE from any state.
    always_comb begin
        state_d = state_q;
        if (!clk_en_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (fall) state_d = ST_START;
                ST_START: if (tick) state_d = rx_s ? ST_IDLE : ST_DATA;
                ST_DATA: begin
                    if (tick && last_bit) begin
`ifdef UART_RX_PARITY_SUPPORT_EN
                        state_d = par_en_q ? ST_PARITY : ST_STOP1;
`else
                        state_d = ST_STOP1;
`endif
                    end
                end
`ifdef UART_RX_PARITY_SUPPORT_EN
                ST_PARITY: if (tick) state_d = ST_STOP1;
`endif
                ST_STOP1: if (tick) state_d = stop2_q ? ST_STOP2 : ST_DONE;
                ST_STOP2: if (tick) state_d = ST_DONE;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Bit-period counter, frame configuration latch, data shift and error flags.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            div_q      <= DIV_MIN;
            cnt_q      <= '0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            stop2_q    <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_SUPPORT_EN
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else if (!clk_en_i) begin
            cnt_q     <= '0;
            bit_cnt_q <= 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (fall) begin
                        // First sample lands half a bit after the edge.
                        div_q      <= div_eff;
                        cnt_q      <= (div_eff >> 1) - DIV_ONE;
                        stop2_q    <= stop_bits_i;
                        ferr_q     <= 1'b0;
                        bit_cnt_q  <= 3'd0;
`ifdef UART_RX_PARITY_SUPPORT_EN
                        par_en_q   <= parity_en_i;
                        par_type_q <= parity_type_i;
                        perr_q     <= 1'b0;
`endif
                    end
                end
                ST_DONE: begin
                    cnt_q <= '0;
                end
                default: begin
                    if (tick) begin
                        cnt_q <= div_q - DIV_ONE;
                        case (state_q)
                            ST_DATA: begin
                                shift_q   <= {rx_s, shift_q[7:1]};
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
`ifdef UART_RX_PARITY_SUPPORT_EN
                            ST_PARITY: perr_q <= ((^shift_q) ^ rx_s) != par_type_q;
`endif
                            ST_STOP1, ST_STOP2: if (!rx_s) ferr_q <= 1'b1;
                            default: ;
                        endcase
                    end else begin
                        cnt_q <= cnt_q - DIV_ONE;
                    end
                end
            endcase
        end
    end

    // Outputs: busy while not idle, result strobes only in an enabled DONE cycle.
    always_comb begin
        push_o       = 1'b0;
        overflow_o   = 1'b0;
        frame_err_o  = 1'b0;
        parity_err_o = 1'b0;
        busy_o       = (state_q != ST_IDLE);
        if (state_q == ST_DONE && clk_en_i) begin
            push_o      = ~fifo_full_i;
            overflow_o  = fifo_full_i;
            frame_err_o = ferr_q;
`ifdef UART_RX_PARITY_SUPPORT_EN
            parity_err_o = perr_q;
`endif
        end
    end

endmodule
